// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline-stage register with valid/ready handshake, 2-entry skid buffer, flush and flush counter
module pipe_stage_skid #(
  parameter int                DATA_W          = 128,
  parameter int                CTRL_W          = 16,
  parameter logic [CTRL_W-1:0] CTRL_FLUSH_MASK = {CTRL_W{1'b1}},
  parameter int                CNT_W           = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_flush_count
);
  logic              main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_w, out_w, ld_main_in, ld_main_skid, ld_skid, squash;

  assign o_ready       = !skid_v_q;
  assign o_valid       = main_v_q;
  assign in_w          = i_valid & o_ready;
  assign out_w         = main_v_q & i_ready;
  assign o_ctrl        = main_ctrl_q & ~(main_v_q ? {CTRL_W{1'b0}} : CTRL_FLUSH_MASK);
  assign o_data        = main_data_q;
  assign o_occupancy   = {1'b0, main_v_q} + {1'b0, skid_v_q};
  assign o_flush_count = cnt_q;

  // Next state: main refills from skid when draining TWO, from input when empty or draining ONE; skid catches input when stalled
  always_comb begin
    ld_main_in   = !i_flush & in_w & (!main_v_q | out_w);
    ld_main_skid = !i_flush & skid_v_q & out_w;
    ld_skid      = !i_flush & in_w & main_v_q & !out_w;
    squash       = i_flush & ((main_v_q & !out_w) | skid_v_q | in_w);
    main_v_d     = !i_flush & (skid_v_q | in_w | (main_v_q & !out_w));
    skid_v_d     = !i_flush & !out_w & (skid_v_q | (in_w & main_v_q));
    main_ctrl_d  = ld_main_skid ? skid_ctrl_q : ld_main_in ? i_ctrl : main_ctrl_q;
    main_data_d  = ld_main_skid ? skid_data_q : ld_main_in ? i_data : main_data_q;
    skid_ctrl_d  = ld_skid ? i_ctrl : skid_ctrl_q;
    skid_data_d  = ld_skid ? i_data : skid_data_q;
    cnt_d        = (squash & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State and payload registers; reset discards held entries immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed scoreboard bench for pipe_stage_skid (default params plus a CNT_W=2 copy)
module tb_pipe_stage_skid;
  logic          clk = 1'b0, reset = 1'b0;
  logic          i_valid = 1'b0, i_ready = 1'b0, i_flush = 1'b0;
  logic [15:0]   i_ctrl = '0;
  logic [127:0]  i_data = '0;
  logic          o_ready, o_valid, o_ready2, o_valid2;
  logic [15:0]   o_ctrl, o_ctrl2;
  logic [127:0]  o_data, o_data2;
  logic [1:0]    o_occupancy, o_occupancy2;
  logic [7:0]    o_flush_count;
  logic [1:0]    o_flush_count2;
  logic [143:0]  q[$];
  int            cnt_m = 0, cnt2_m = 0, total = 0, passed = 0;

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready), .i_ctrl(i_ctrl), .i_data(i_data),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_ctrl(o_ctrl), .o_data(o_data),
    .o_occupancy(o_occupancy), .o_flush_count(o_flush_count));

  pipe_stage_skid #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready2), .i_ctrl(i_ctrl), .i_data(i_data),
    .i_flush(i_flush), .o_valid(o_valid2), .i_ready(i_ready), .o_ctrl(o_ctrl2), .o_data(o_data2),
    .o_occupancy(o_occupancy2), .o_flush_count(o_flush_count2));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    chk("o_valid", o_valid, q.size() != 0);
    chk("o_ready", o_ready, q.size() < 2);
    chk("o_occupancy", o_occupancy, q.size());
    chk("o_ctrl", o_ctrl, q.size() != 0 ? q[0][143:128] : 16'h0);
    if (q.size() != 0) chk("o_data", o_data, q[0][127:0]);
    chk("o_flush_count", o_flush_count, cnt_m);
    chk("o_flush_count_w2", o_flush_count2, cnt2_m);
  endtask

  task automatic step(input logic v, input logic [15:0] c, input logic [127:0] d, input logic rdy, input logic fl);
    bit in_m, out_m;
    i_valid = v; i_ctrl = c; i_data = d; i_ready = rdy; i_flush = fl;
    #2;
    check_outputs();
    in_m  = v && q.size() < 2;
    out_m = q.size() != 0 && rdy;
    @(posedge clk);
    #1;
    if (out_m) void'(q.pop_front());
    if (fl) begin
      if (q.size() != 0 || in_m) begin
        if (cnt_m < 255) cnt_m++;
        if (cnt2_m < 3) cnt2_m++;
      end
      q.delete();
    end else if (in_m) q.push_back({c, d});
  endtask

  initial begin
    #1 reset = 1'b1;
    i_valid = 1'b1; i_ctrl = 16'hFFFF; i_data = 128'hDEAD;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_o_ready", o_ready, 1'b1);
    chk("rst_o_ctrl", o_ctrl, 16'h0);
    chk("rst_o_data", o_data, 128'h0);
    chk("rst_o_occupancy", o_occupancy, 2'd0);
    chk("rst_o_flush_count", o_flush_count, 8'd0);
    reset = 1'b0;
    // 1: single entry, one-cycle latency
    step(1, 16'h00A5, 128'd1, 1, 0);
    chk("t1_o_ctrl", o_ctrl, 16'h00A5);
    step(0, 0, 0, 1, 0);
    // 2: stream 8 entries at full rate
    for (int i = 1; i <= 8; i++) step(1, 16'(i * 16'h0111), 128'(i), 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    // 3: back-pressure into skid, then drain back-to-back
    step(1, 16'h1234, 128'hA, 0, 0);
    step(1, 16'h5678, 128'hB, 0, 0);
    step(1, 16'h9ABC, 128'hC, 0, 0);
    chk("t3_o_data_A", o_data, 128'hA);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    // 4: flush in TWO, then flush while empty
    step(1, 16'h00F0, 128'h11, 0, 0);
    step(1, 16'h0F00, 128'h22, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("t4_o_ctrl_masked", o_ctrl, 16'h0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("t4_count_one", o_flush_count, 8'd1);
    // flush with only an offered input squashes it and counts
    step(1, 16'h0077, 128'h33, 0, 1);
    // flush while the sole entry drains downstream does not count
    step(1, 16'h0055, 128'h44, 0, 0);
    step(0, 0, 0, 1, 1);
    // 5: repeated squashing flushes saturate the narrow counter
    for (int i = 0; i < 5; i++) begin
      step(1, 16'(16'h0100 + i), 128'(100 + i), 0, 0);
      step(0, 0, 0, 0, 1);
    end
    step(0, 0, 0, 0, 0);
    chk("t5_count_w2_sat", o_flush_count2, 2'd3);
    // 6: async reset in TWO mid-cycle
    step(1, 16'hAAAA, 128'h55, 0, 0);
    step(1, 16'hBBBB, 128'h66, 0, 0);
    chk("t6_pre_occupancy", o_occupancy, 2'd2);
    reset = 1'b1;
    #1;
    chk("t6_rst_o_valid", o_valid, 1'b0);
    chk("t6_rst_o_ready", o_ready, 1'b1);
    chk("t6_rst_o_occupancy", o_occupancy, 2'd0);
    chk("t6_rst_o_data", o_data, 128'h0);
    q.delete(); cnt_m = 0; cnt2_m = 0;
    #1 reset = 1'b0;
    step(1, 16'h00C3, 128'h77, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $fatal(1, "FAIL timeout: observed no finish expected finish");
  end
endmodule
